data_mem: RTL and testbench

Byte-addressable data memory stage for the single-cycle MIPS core. It sits directly downstream of the ALU and consumes the ALU result as the effective address. It supports word and byte loads and stores (LW/SW/LB/LBU/SB), with optional halfword access. It flags misaligned, out-of-range and illegal accesses instead of corrupting memory.

---
 rtl/data_mem_if.sv | 21 ++
 rtl/data_mem.sv | 113 +++++++++++
 tb/tb_data_mem.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Bus bundle between the ALU/control side and the data memory stage.
interface data_mem_if;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        MemWrite;
    logic [2:0]  MemOp;
    logic [31:0] RD;
    logic        Err;
    logic        ErrSticky;
    logic [31:0] StoreCnt;

    modport master (
        output Addr, WD, MemWrite, MemOp,
        input  RD, Err, ErrSticky, StoreCnt
    );

    modport slave (
        input  Addr, WD, MemWrite, MemOp,
        output RD, Err, ErrSticky, StoreCnt
    );
endinterface

// File: rtl/data_mem.sv
// Byte-addressable data memory for the single-cycle MIPS core.
// Word/byte loads and stores; halfword access compiled in only when the
// DM_HALF_EN macro is defined. Faulting accesses never modify the array.
module data_mem #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    logic [31:0]           mem_q [DEPTH];
    logic                  sticky_q;
    logic [31:0]           store_cnt_q;
    logic [31:0]           store_cnt_d;

    logic                  err;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [31:0]           rd_data;
    logic [31:0]           wr_word_d;
    logic                  commit;

    assign word_idx = bus.Addr[ADDR_WIDTH-1:2];
    assign lane     = bus.Addr[1:0];
    assign rd_word  = mem_q[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign commit   = bus.MemWrite && !err;

    // Access fault: out-of-range address, misalignment or illegal MemOp.
    always_comb begin
        err = 1'b0;
        if (bus.Addr[31:ADDR_WIDTH] != '0) begin
            err = 1'b1;
        end
        case (bus.MemOp)
            3'd0: if (lane != 2'b00) err = 1'b1;
            3'd1, 3'd2: ;
`ifdef DM_HALF_EN
            3'd3, 3'd4: if (bus.Addr[0]) err = 1'b1;
`else
            3'd3, 3'd4: err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

    // Load path: lane extraction and extension, forced to zero on fault.
    always_comb begin
        rd_data = '0;
        case (bus.MemOp)
            3'd0: rd_data = rd_word;
            3'd1: rd_data = {{24{rd_byte[7]}}, rd_byte};
            3'd2: rd_data = {24'h0, rd_byte};
`ifdef DM_HALF_EN
            3'd3: rd_data = {{16{rd_word[{bus.Addr[1], 4'h0} + 5'd15]}},
                             rd_word[{bus.Addr[1], 4'h0} +: 16]};
            3'd4: rd_data = {16'h0, rd_word[{bus.Addr[1], 4'h0} +: 16]};
`endif
            default: rd_data = '0;
        endcase
        if (err) begin
            rd_data = '0;
        end
    end

    // Store merge: replace only the addressed lane(s) of the current word.
    always_comb begin
        wr_word_d = rd_word;
        case (bus.MemOp)
            3'd0: wr_word_d = bus.WD;
            3'd1, 3'd2: wr_word_d[{lane, 3'b000} +: 8] = bus.WD[7:0];
`ifdef DM_HALF_EN
            3'd3, 3'd4: wr_word_d[{bus.Addr[1], 4'h0} +: 16] = bus.WD[15:0];
`endif
            default: wr_word_d = rd_word;
        endcase
    end

    assign store_cnt_d = commit ? store_cnt_q + 32'd1 : store_cnt_q;

    // Array update: reset clears every word, otherwise commit fault-free stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    // Status registers: sticky fault flag and committed-store counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q    <= 1'b0;
            store_cnt_q <= '0;
        end else begin
            if (err) begin
                sticky_q <= 1'b1;
            end
            store_cnt_q <= store_cnt_d;
        end
    end

    assign bus.RD        = rd_data;
    assign bus.Err       = err;
    assign bus.ErrSticky = sticky_q;
    assign bus.StoreCnt  = store_cnt_q;
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: table of per-cycle vectors with a
// scoreboard queue, plus hand sequences for counter wrap and illegal MemOp.
module tb_data_mem;
`ifdef DM_HALF_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] cnt;
        logic        sticky;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    data_mem_if bus ();

    data_mem #(.ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
        end
    endtask

    task automatic addv(input logic rst, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err,
                        input logic [31:0] cnt, input logic sticky);
        vec_t v;
        v.rst = rst; v.we = we; v.op = op; v.addr = addr; v.wd = wd;
        v.rd = rd; v.err = err; v.cnt = cnt; v.sticky = sticky;
        vecs.push_back(v);
    endtask

    // Drive one cycle after the previous edge, push expectation, compare at negedge.
    task automatic apply(input vec_t v, input int row);
        vec_t e;
        @(posedge clk); #1;
        reset        = v.rst;
        bus.MemWrite = v.we;
        bus.MemOp    = v.op;
        bus.Addr     = v.addr;
        bus.WD       = v.wd;
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", row, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("RD", row, bus.RD, e.rd);
            chk("Err", row, {31'd0, bus.Err}, {31'd0, e.err});
            chk("StoreCnt", row, bus.StoreCnt, e.cnt);
            chk("ErrSticky", row, {31'd0, bus.ErrSticky}, {31'd0, e.sticky});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c;
        vec_t v;
        reset = 1'b1; bus.MemWrite = 1'b0; bus.MemOp = 3'd0;
        bus.Addr = '0; bus.WD = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // rst we op addr wd | rd err cnt sticky (values seen during the cycle)
        addv(0,0,3'd0,32'h000,32'h0,        32'h0,0,0,0);
        addv(0,0,3'd0,32'hFFC,32'h0,        32'h0,0,0,0);
        addv(0,0,3'd0,32'h400,32'h0,        32'h0,0,0,0);
        addv(0,1,3'd0,32'h010,32'h12345678, 32'h0,0,0,0);
        addv(0,0,3'd1,32'h011,32'h0,        32'h00000056,0,1,0);
        addv(0,0,3'd1,32'h013,32'h0,        32'h00000012,0,1,0);
        addv(0,1,3'd1,32'h012,32'hAAAAAA9C, 32'h00000034,0,1,0);
        addv(0,0,3'd0,32'h010,32'h0,        32'h129C5678,0,2,0);
        addv(0,0,3'd1,32'h012,32'h0,        32'hFFFFFF9C,0,2,0);
        addv(0,0,3'd2,32'h012,32'h0,        32'h0000009C,0,2,0);
        addv(0,1,3'd0,32'h006,32'hFFFFFFFF, 32'h0,1,2,0);
        addv(0,0,3'd0,32'h004,32'h0,        32'h0,0,2,1);
        addv(0,1,3'd0,32'h1000,32'h00000001,32'h0,1,2,1);
        addv(0,0,3'd0,32'h000,32'h0,        32'h0,0,2,1);
        addv(1,1,3'd0,32'h008,32'hDEADBEEF, 32'h0,0,2,1);
        addv(0,0,3'd0,32'h008,32'h0,        32'h0,0,0,0);
        addv(0,1,3'd0,32'h020,32'h11223344, 32'h0,0,0,0);
        addv(0,1,3'd3,32'h022,32'h0000BEEF, H ? 32'h00001122 : 32'h0, !H, 1, 0);
        c = H ? 32'd2 : 32'd1;
        addv(0,0,3'd0,32'h020,32'h0, H ? 32'hBEEF3344 : 32'h11223344, 0, c, !H);
        addv(0,0,3'd3,32'h022,32'h0, H ? 32'hFFFFBEEF : 32'h0, !H, c, !H);
        addv(0,0,3'd4,32'h022,32'h0, H ? 32'h0000BEEF : 32'h0, !H, c, !H);
        addv(0,0,3'd3,32'h021,32'h0,        32'h0,1,c,!H);
        addv(0,0,3'd0,32'h020,32'h0, H ? 32'hBEEF3344 : 32'h11223344, 0, c, 1);
        addv(0,1,3'd0,32'h040,32'hAAAA0001, 32'h0,0,c,1);
        addv(0,1,3'd0,32'h044,32'hBBBB0002, 32'h0,0,c+1,1);
        addv(0,0,3'd0,32'h040,32'h0,        32'hAAAA0001,0,c+2,1);
        addv(0,0,3'd0,32'h044,32'h0,        32'hBBBB0002,0,c+2,1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Counter wrap: preload the counter, then commit one byte store.
        force dut.store_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.store_cnt_q;
        v.rst = 0; v.we = 1; v.op = 3'd1; v.addr = 32'h30; v.wd = 32'h00000055;
        v.rd = 32'h0; v.err = 0; v.cnt = 32'hFFFFFFFF; v.sticky = 1;
        apply(v, 100);
        v.we = 0; v.op = 3'd2; v.rd = 32'h00000055; v.cnt = 32'h0;
        apply(v, 101);

        // Illegal MemOp 7 with MemWrite: faults, writes nothing, counts nothing.
        v.we = 1; v.op = 3'd7; v.addr = 32'h40; v.wd = 32'h12345678;
        v.rd = 32'h0; v.err = 1; v.cnt = 32'h0;
        apply(v, 102);
        v.we = 0; v.op = 3'd0; v.rd = 32'hAAAA0001; v.err = 0;
        apply(v, 103);

        if (sb.size() != 0) begin
            chk("scoreboard_leftover", 0, sb.size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
